// File: rtl/uart_rx.sv
// uart_rx -- 8N1 serial receiver with a small show-ahead receive FIFO.
//
// The asynchronous rx line passes through a two-flop synchronizer. A bit-timing
// counter drives the deframing FSM, which samples every bit at mid-bit. Complete
// bytes go into a circular FIFO that the CPU bus logic pops.
//
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit between
// the data bits and the stop bit. Without it, parityError is tied low.
//
// Ports:
//   clk          system clock; all logic runs on the rising edge
//   reset        synchronous, active-high
//   rx           asynchronous serial input, idle high
//   readEnable   pop the FIFO head at this clock edge (ignored when empty)
//   clearErrors  one-cycle pulse that clears the sticky error flags
//   Data         FIFO head byte, show-ahead; 8'h00 when the FIFO is empty
//   rxValid      FIFO not empty
//   rxFull       FIFO full
//   frameError   sticky: stop bit sampled low
//   overrun      sticky: a byte completed while the FIFO was full
//   parityError  sticky: parity mismatch (parity build only)
module uart_rx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       readEnable,
  input  logic       clearErrors,
  output logic [7:0] Data,
  output logic       rxValid,
  output logic       rxFull,
  output logic       frameError,
  output logic       overrun,
  output logic       parityError
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t           state;
  logic             sync_p0;
  logic             sync_p1;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             push_vld;
`ifdef UART_RX_PARITY_EN
  logic             par_bad;
`endif

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             empty;
  logic             full;
  logic             pop;
  logic             wr_en;

  // ---- Stage p0 -> p1: two-flop synchronizer; idle-high reset avoids a false start
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= rx;
      sync_p1 <= sync_p0;
    end
  end

  assign rx_s = sync_p1;

  // ---- Stage p1 -> deframer: bit timing, shifting and error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      push_vld   <= 1'b0;
      frameError <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad     <= 1'b0;
      parityError <= 1'b0;
`endif
    end else begin
      push_vld <= 1'b0;
      // Clears come first so that a set in the same cycle wins.
      if (clearErrors) frameError <= 1'b0;
`ifdef UART_RX_PARITY_EN
      if (clearErrors) parityError <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          // Re-check the line at mid start bit to reject short glitches.
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            par_bad <= ((^shift) != rx_s);
            if ((^shift) != rx_s) parityError <= 1'b1;
            state   <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              push_vld <= !par_bad;
`else
              push_vld <= 1'b1;
`endif
              state <= IDLE;
            end else begin
              frameError <= 1'b1;
              state      <= BREAK;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        BREAK: begin
          // Hold here until the line returns high so a stuck-low line never retriggers.
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parityError = 1'b0;
`endif

  // ---- Deframer -> FIFO: push lands one cycle after the stop-bit sample
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign pop   = readEnable && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_en = push_vld && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (clearErrors) overrun <= 1'b0;
      if (push_vld && !wr_en) overrun <= 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: ;
      endcase
    end
  end

  assign Data    = empty ? 8'h00 : mem[rd_ptr];
  assign rxValid = !empty;
  assign rxFull  = full;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receiver for the 8-bit CPU's UART peripheral, complementing the existing transmit path. It oversamples the asynchronous `rx` line with the system clock, deframes 8N1 characters (LSB first), and buffers received bytes in a small show-ahead FIFO. The CPU bus logic pops bytes from the FIFO. Status bits (valid, framing error, overrun) feed the peripheral status register.

Parameters:
- CLKS_PER_BIT, 8, system clocks per bit period; even, >= 4.
- FIFO_DEPTH, 4, receive FIFO entries; power of 2, >= 2.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- reset, input, 1, synchronous, active-high.
- rx, input, 1, asynchronous serial line; idle high.
- readEnable, input, 1, pop the FIFO head at the clock edge.
- clearErrors, input, 1, one-cycle pulse that clears the sticky error flags.
- Data, output, 8, FIFO head byte; show-ahead; 8'h00 when empty.
- rxValid, output, 1, FIFO not empty.
- rxFull, output, 1, FIFO full.
- frameError, output, 1, sticky; stop bit sampled low.
- overrun, output, 1, sticky; a byte was completed while the FIFO was full.
- parityError, output, 1, sticky; parity mismatch (see Optional Feature).

Behaviour:
- Reset:
  - Single clock domain; reset is synchronous and active-high.
  - Reset sets state to IDLE, empties the FIFO, and zeroes the counters and shift register.
  - Reset drives Data=0, rxValid=0, rxFull=0, frameError=0, overrun=0, parityError=0.
  - Both synchronizer flops reset to 1.
  - Reset mid-frame aborts the frame; the partial byte is lost.
- Synchronizer: `rx` passes through 2 flops to give rxS; all FSM decisions use rxS.
- FSM, driven by a bit-timing counter `cnt`:
  - IDLE: when rxS==0, go to START with cnt=0.
  - START: count to CLKS_PER_BIT/2-1.
    - If rxS==0 at that point, go to DATA with cnt=0 and bitIdx=0.
    - Otherwise treat it as a glitch and return to IDLE; nothing is flagged.
  - DATA: at cnt==CLKS_PER_BIT-1, shift rxS into the shift register MSB (right shift, so LSB arrives first), reset cnt, and increment bitIdx.
    - After bit 7, go to PARITY if enabled, else STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rxS.
    - If 1, push the byte and go to IDLE.
    - If 0, set frameError, discard the byte, and go to BREAK.
  - BREAK: wait for rxS==1, then go to IDLE. This prevents a held-low line from retriggering.
- Timing:
  - Samples land at mid-bit.
  - Push occurs on the cycle after the stop-bit sample.
  - rxValid rises exactly 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clocks after the first clk edge that sees `rx` low; 79 for CLKS_PER_BIT=8.
- FIFO:
  - Circular buffer with wrap-around read/write pointers and an occupancy count of width $clog2(FIFO_DEPTH)+1.
  - Data = mem[rdPtr], driven combinationally.
  - Pop with readEnable while empty is ignored; pointers do not move.
  - Push while full drops the new byte, sets overrun, and leaves the contents unchanged.
  - Simultaneous push and pop while full: both take effect, count is unchanged, no overrun.
  - Simultaneous push and pop while empty: push only.
- Sticky flags:
  - frameError, overrun and parityError are set by their events and cleared by clearErrors.
  - If set and clear land in the same cycle, set wins.
  - Errors never block reception of later frames.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA, lasting one bit period and sampled at mid-bit. Even parity is used.
  - On mismatch, parityError is set and the byte is discarded; the stop bit is still checked.
  - Frame length is 11 bits; rxValid latency increases by CLKS_PER_BIT.
- Undefined: no PARITY state, and parityError is tied to 0.

Test Plan:
- Reset, then drive `rx` with frame 0xAA (line bits 0,0,1,0,1,0,1,0,1,1; 8 clocks/bit) -> rxValid=1 at clock 79 after the start edge, Data=8'hAA; readEnable for 1 cycle -> rxValid=0, Data=8'h00.
- Send 0x01, 0x80, 0xFF, 0x00 back to back, then 0x55 without reading -> FIFO returns 01,80,FF,00 in order; rxFull=1 after the 4th byte; overrun=1 after 0x55; 0x55 is not stored. clearErrors -> overrun=0.
- Frame 0x3C with the stop bit driven low, held low 30 clocks, then high, then a valid 0x3C -> frameError=1 and the first byte is dropped; no spurious frame during the low period; the second 0x3C is received.
- Low glitch on `rx` lasting 2 clocks in IDLE -> FSM returns to IDLE; rxValid stays 0 and no flags are set.
- FIFO full and readEnable asserted in the same cycle as a new byte's push -> no overrun, count stays 4, and the oldest byte is removed.
- Assert reset at DATA bit 3 of a frame, then send 0xC3 -> no byte from the aborted frame; 0xC3 is received correctly. With UART_RX_PARITY_EN, 0xC3 with a bad parity bit -> parityError=1 and nothing is pushed.
